ram_arbiter: RTL and testbench



---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/ram_arbiter_rr_arb2.sv | 19 +
 rtl/ram_arbiter.sv | 150 +++++++++++++++
 tb/tb_ram_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM port arbiter.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int unsigned M_CORE     = 0;
   localparam int unsigned M_AUX      = 1;
   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin winner pick; purely combinational.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic [1:0] mask_i,
   input  logic       last_i,
   output logic       win_valid_o,
   output logic       win_idx_o
);

   logic [1:0] eff;

   assign eff         = req_i & ~mask_i;
   assign win_valid_o = |eff;
   // On a tie the master that did not win last time goes next.
   assign win_idx_o   = (&eff) ? ~last_i : eff[M_AUX];

endmodule

// File: rtl/ram_arbiter.sv
// Serialises two masters onto one synchronous RAM port and routes read data back.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                m0_req_i,
   input  logic                m0_we_i,
   input  logic [ADDR_W-1:0]   m0_addr_i,
   input  logic [DATA_W/8-1:0] m0_addr_sel_i,
   input  logic [DATA_W-1:0]   m0_wdata_i,
   output logic                m0_gnt_o,
   output logic                m0_rvalid_o,
   output logic [DATA_W-1:0]   m0_rdata_o,
   input  logic                m1_req_i,
   input  logic                m1_we_i,
   input  logic [ADDR_W-1:0]   m1_addr_i,
   input  logic [DATA_W/8-1:0] m1_addr_sel_i,
   input  logic [DATA_W-1:0]   m1_wdata_i,
   output logic                m1_gnt_o,
   output logic                m1_rvalid_o,
   output logic [DATA_W-1:0]   m1_rdata_o,
   output logic                ram_ce_o,
   output logic                ram_wr_en_o,
   output logic [ADDR_W-1:0]   ram_addr_o,
   output logic [DATA_W/8-1:0] ram_addr_sel_o,
   output logic [DATA_W-1:0]   ram_wr_data_o,
   input  logic [DATA_W-1:0]   ram_data_in_i
);

   localparam int unsigned SEL_W = DATA_W / 8;

   logic [1:0]              req, we;
   logic [1:0][ADDR_W-1:0]  addr;
   logic [1:0][SEL_W-1:0]   sel;
   logic [1:0][DATA_W-1:0]  wdata;

   assign req   = {m1_req_i, m0_req_i};
   assign we    = {m1_we_i, m0_we_i};
   assign addr  = {m1_addr_i, m0_addr_i};
   assign sel   = {m1_addr_sel_i, m0_addr_sel_i};
   assign wdata = {m1_wdata_i, m0_wdata_i};

   state_e                  state_q, state_d;
   logic                    last_q, last_d;
   logic                    idx_q, idx_d;
   logic                    we_q, we_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;
   logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;

   logic       arb_en, win_valid, win_idx;
   logic [1:0] mask;

   rr_arb2 u_arb (
      .req_i       (req),
      .mask_i      (mask),
      .last_i      (last_q),
      .win_valid_o (win_valid),
      .win_idx_o   (win_idx)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      idx_d   = idx_q;
      we_d    = we_q;
      addr_d  = addr_q;
      sel_d   = sel_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      arb_en  = 1'b0;
      mask    = 2'b00;
      unique case (state_q)
         IDLE: arb_en = 1'b1;
         XFER: begin
            // The winner's req is still up while it sees gnt; mask it so it cannot win twice.
            if (we_q) begin
               arb_en      = 1'b1;
               mask[idx_q] = 1'b1;
            end else begin
               state_d = RESP;
            end
         end
         RESP: begin
            arb_en         = 1'b1;
            rdata_d[idx_q] = ram_data_in_i;
         end
         default: state_d = IDLE;
      endcase
      if (arb_en) begin
         if (win_valid) begin
            state_d = XFER;
            idx_d   = win_idx;
            last_d  = win_idx;
            we_d    = we[win_idx];
            addr_d  = addr[win_idx];
            sel_d   = sel[win_idx];
            wdata_d = wdata[win_idx];
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         idx_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         sel_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         sel_q   <= sel_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   logic xfer, resp;
   assign xfer = (state_q == XFER);
   assign resp = (state_q == RESP);

   assign ram_ce_o       = xfer;
   assign ram_wr_en_o    = xfer & we_q;
   assign ram_addr_o     = addr_q;
   assign ram_addr_sel_o = sel_q;
   assign ram_wr_data_o  = wdata_q;

   assign m0_gnt_o    = xfer & (idx_q == 1'(M_CORE));
   assign m1_gnt_o    = xfer & (idx_q == 1'(M_AUX));
   assign m0_rvalid_o = resp & (idx_q == 1'(M_CORE));
   assign m1_rvalid_o = resp & (idx_q == 1'(M_AUX));
   // rdata_d already shows the live RAM word during RESP, so rvalid and data line up.
   assign m0_rdata_o  = rdata_d[M_CORE];
   assign m1_rdata_o  = rdata_d[M_AUX];

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed scoreboard bench for ram_arbiter: expected grants/read returns queued by stimulus, popped by a monitor.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]  m0_sel, m1_sel;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        ram_ce, ram_wr_en;
   logic [31:0] ram_addr, ram_wr_data;
   logic [3:0]  ram_sel;
   logic [31:0] ram_data_in = 32'h0;

   ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_addr_sel_i(m0_sel),
      .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_addr_sel_i(m1_sel),
      .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
      .ram_ce_o(ram_ce), .ram_wr_en_o(ram_wr_en), .ram_addr_o(ram_addr),
      .ram_addr_sel_o(ram_sel), .ram_wr_data_o(ram_wr_data), .ram_data_in_i(ram_data_in)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'h20:  rom = 32'h1234_5678;
         32'h40:  rom = 32'hCAFE_F00D;
         default: rom = ~a;
      endcase
   endfunction

   // Synchronous RAM: read word appears the cycle after the strobe.
   always @(posedge clk) if (ram_ce && !ram_wr_en) ram_data_in <= rom(ram_addr);

   typedef struct {
      int          cyc;
      bit          rv;
      bit          m;
      bit          we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      else n_pass++;
   endtask

   task automatic exp_gnt(input int c, input bit m, input bit we, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d);
      exp_t e;
      e = '{cyc: c, rv: 1'b0, m: m, we: we, addr: a, sel: s, data: d};
      sb.push_back(e);
   endtask

   task automatic exp_rv(input int c, input bit m, input logic [31:0] d);
      exp_t e;
      e = '{cyc: c, rv: 1'b1, m: m, we: 1'b0, addr: 32'h0, sel: 4'h0, data: d};
      sb.push_back(e);
   endtask

   task automatic drive(input bit m, input bit req, input bit we, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
      if (!m) begin
         m0_req = req; m0_we = we; m0_addr = a; m0_sel = s; m0_wdata = d;
      end else begin
         m1_req = req; m1_we = we; m1_addr = a; m1_sel = s; m1_wdata = d;
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, 128'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_ce, ram_wr_en}), 128'(0));
      chk({tag, "_cmd"}, 128'({ram_addr, ram_sel, ram_wr_data}), 128'(0));
      chk({tag, "_rdata"}, 128'({m0_rdata, m1_rdata}), 128'(0));
   endtask

   // Monitor: every grant or read return must match the head of the scoreboard.
   exp_t        mon_e;
   logic [1:0]  mon_g, mon_r;
   logic [1:0][31:0] mon_rd;
   always @(negedge clk) begin
      mon_g  = {m1_gnt, m0_gnt};
      mon_r  = {m1_rvalid, m0_rvalid};
      mon_rd = {m1_rdata, m0_rdata};
      chk("wr_en_without_ce", 128'(ram_wr_en & ~ram_ce), 128'(0));
      for (int m = 0; m < 2; m++) begin
         if (mon_g[m] || mon_r[m]) begin
            if (sb.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_evt: master %0d gnt=%0b rvalid=%0b at cycle %0d, expected none",
                        m, mon_g[m], mon_r[m], cyc);
            end else begin
               mon_e = sb.pop_front();
               chk("evt_cycle", 128'(cyc), 128'(mon_e.cyc));
               chk("evt_master_kind", 128'({m[0], mon_r[m]}), 128'({mon_e.m, mon_e.rv}));
               if (mon_r[m])
                  chk("rdata", 128'(mon_rd[m]), 128'(mon_e.data));
               else
                  chk("cmd", 128'({ram_wr_en, ram_addr, ram_sel, ram_wr_data}),
                      128'({mon_e.we, mon_e.addr, mon_e.sel, mon_e.data}));
            end
         end
      end
   end

   int t;
   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
      drive(1, 0, 0, 32'h0, 4'h0, 32'h0);
      #2 chk_zero("reset_init");
      step(2);
      rst_n = 1'b1;
      step(1);

      // Single write from m0
      t = cyc;
      drive(0, 1, 1, 32'h10, 4'hF, 32'hDEAD_BEEF);
      exp_gnt(t + 1, 0, 1, 32'h10, 4'hF, 32'hDEAD_BEEF);
      step(1);
      m0_req = 1'b0;
      step(1);
      chk("wr_back_to_idle", 128'(ram_ce), 128'(0));
      step(1);
      chk("wr_sb_empty", 128'(sb.size()), 128'(0));

      // Single read from m1
      t = cyc;
      drive(1, 1, 0, 32'h20, 4'hF, 32'h0);
      exp_gnt(t + 1, 1, 0, 32'h20, 4'hF, 32'h0);
      exp_rv(t + 2, 1, 32'h1234_5678);
      step(1);
      m1_req = 1'b0;
      step(3);
      chk("rd_sb_empty", 128'(sb.size()), 128'(0));
      chk("rd_m1_rdata_held", 128'(m1_rdata), 128'(32'h1234_5678));

      // Contention from reset: alternate one write per cycle, m0 first
      rst_n = 1'b0;
      #1 chk_zero("reset_idle");
      step(1);
      rst_n = 1'b1;
      t = cyc;
      drive(0, 1, 1, 32'h100, 4'h3, 32'hA0A0_A0A0);
      drive(1, 1, 1, 32'h200, 4'hC, 32'hB1B1_B1B1);
      exp_gnt(t + 1, 0, 1, 32'h100, 4'h3, 32'hA0A0_A0A0);
      exp_gnt(t + 2, 1, 1, 32'h200, 4'hC, 32'hB1B1_B1B1);
      exp_gnt(t + 3, 0, 1, 32'h100, 4'h3, 32'hA0A0_A0A0);
      exp_gnt(t + 4, 1, 1, 32'h200, 4'hC, 32'hB1B1_B1B1);
      step(4);
      m0_req = 1'b0;
      m1_req = 1'b0;
      step(2);
      chk("cont_sb_empty", 128'(sb.size()), 128'(0));

      // Same master alone: grants two cycles apart; zero byte-select still strobes
      t = cyc;
      drive(0, 1, 1, 32'h30, 4'h0, 32'h1);
      exp_gnt(t + 1, 0, 1, 32'h30, 4'h0, 32'h1);
      exp_gnt(t + 3, 0, 1, 32'h30, 4'h0, 32'h2);
      exp_gnt(t + 5, 0, 1, 32'h30, 4'h0, 32'h3);
      step(1);
      m0_wdata = 32'h2;
      step(2);
      m0_wdata = 32'h3;
      step(2);
      m0_req = 1'b0;
      step(2);
      chk("same_sb_empty", 128'(sb.size()), 128'(0));

      // Reset during the XFER of a read: no rvalid, then m0 wins first again
      t = cyc;
      drive(0, 1, 0, 32'h40, 4'hF, 32'h0);
      step(1);
      chk("rst_rd_gnt", 128'({m0_gnt, ram_ce, ram_wr_en, ram_addr}), 128'({1'b1, 1'b1, 1'b0, 32'h40}));
      #1 rst_n = 1'b0;
      #1 chk_zero("reset_mid_read");
      m0_req = 1'b0;
      step(2);
      chk_zero("reset_hold");
      rst_n = 1'b1;
      t = cyc;
      drive(0, 1, 1, 32'h50, 4'hF, 32'h55);
      drive(1, 1, 1, 32'h60, 4'hF, 32'h66);
      exp_gnt(t + 1, 0, 1, 32'h50, 4'hF, 32'h55);
      exp_gnt(t + 2, 1, 1, 32'h60, 4'hF, 32'h66);
      step(2);
      m0_req = 1'b0;
      m1_req = 1'b0;
      step(2);
      chk("rst_sb_empty", 128'(sb.size()), 128'(0));

      // Withdrawal: m1 pulses req while m0 read is in XFER and is never granted
      t = cyc;
      drive(0, 1, 0, 32'h44, 4'hF, 32'h0);
      exp_gnt(t + 1, 0, 0, 32'h44, 4'hF, 32'h0);
      exp_rv(t + 2, 0, 32'hFFFF_FFBB);
      step(1);
      m0_req = 1'b0;
      drive(1, 1, 1, 32'h80, 4'hF, 32'h77);
      step(1);
      m1_req = 1'b0;
      step(3);
      chk("wd_sb_empty", 128'(sb.size()), 128'(0));
      chk("wd_m0_rdata_held", 128'(m0_rdata), 128'(32'hFFFF_FFBB));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
